// File: rtl/ram_read_responder_if.sv
// Bus bundle for ram_read_responder: SPI receive words, Ibex-style RAM read port,
// SPI transmit handshake and status flags.
interface ram_read_responder_if #(
    parameter int WIDTH = 32
);
    logic             spi_done;
    logic [WIDTH-1:0] spi_rx_data;
    logic             abort;
    logic             mem_req;
    logic [WIDTH-1:0] mem_addr;
    logic             mem_gnt;
    logic             mem_rvalid;
    logic [WIDTH-1:0] mem_rdata;
    logic             tx_valid;
    logic [WIDTH-1:0] tx_data;
    logic             tx_ready;
    logic             busy;
    logic             rd_done;

    modport slave (
        input  spi_done, spi_rx_data, abort, mem_gnt, mem_rvalid, mem_rdata, tx_ready,
        output mem_req, mem_addr, tx_valid, tx_data, busy, rd_done
    );

    modport master (
        output spi_done, spi_rx_data, abort, mem_gnt, mem_rvalid, mem_rdata, tx_ready,
        input  mem_req, mem_addr, tx_valid, tx_data, busy, rd_done
    );
endinterface

// File: rtl/ram_read_responder.sv
// Decodes READ cmd/addr/size from SPI, prefetches words from RAM into a small buffer and streams
// them to the SPI transmitter. Optional checksum trailer word: define RD_CHKSUM_EN.
module ram_read_responder #(
    parameter int         WIDTH     = 32,
    parameter int         BUF_DEPTH = 4,
    parameter logic [7:0] CMD_READ  = 8'h02
) (
    input  logic                 clk_sys,
    input  logic                 rst_sys_n,
    ram_read_responder_if.slave  bus
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(BUF_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GET_ADDR = 3'd1,
        S_GET_SIZE = 3'd2,
        S_XFER     = 3'd3,
        S_DONE     = 3'd4,
        S_FLUSH    = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] issue_left_q, issue_left_d;
    logic [WIDTH-1:0] tx_left_q, tx_left_d;
    logic [CW-1:0]    in_flight_q, in_flight_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] buf_q [BUF_DEPTH];
    logic             req_q, req_d, busy_q, rd_done_q;
    logic             abort_s, gnt_s, rvalid_s, push_s, hs_s, pop_data_s, pop_trl_s;
    logic             req_hold_s, trailer_s, tx_valid_s;
    logic [WIDTH-1:0] tx_data_s;
    logic [CW:0]      occ_s;
`ifdef RD_CHKSUM_EN
    logic [WIDTH-1:0] chk_q, chk_d;
`endif

    assign abort_s    = bus.abort && ((state_q == S_GET_ADDR) || (state_q == S_GET_SIZE) ||
                                      (state_q == S_XFER));
    assign gnt_s      = req_q && bus.mem_gnt;
    assign req_hold_s = req_q && !bus.mem_gnt;
    assign rvalid_s   = bus.mem_rvalid && (in_flight_q != {CW{1'b0}});
    assign push_s     = rvalid_s && (state_q == S_XFER) && !abort_s;

    // The trailer is presented only once every data word has been accepted.
`ifdef RD_CHKSUM_EN
    assign trailer_s  = (state_q == S_XFER) && (tx_left_q == {WIDTH{1'b0}});
    assign tx_data_s  = (cnt_q != {CW{1'b0}}) ? buf_q[rd_ptr_q] : chk_q;
`else
    assign trailer_s  = 1'b0;
    assign tx_data_s  = buf_q[rd_ptr_q];
`endif
    assign tx_valid_s = (cnt_q != {CW{1'b0}}) || trailer_s;
    assign hs_s       = tx_valid_s && bus.tx_ready && (state_q == S_XFER) && !abort_s;
    assign pop_data_s = hs_s && (cnt_q != {CW{1'b0}});
    assign pop_trl_s  = hs_s && (cnt_q == {CW{1'b0}});

    assign bus.mem_req  = req_q;
    assign bus.mem_addr = addr_q;
    assign bus.tx_valid = tx_valid_s;
    assign bus.tx_data  = tx_data_s;
    assign bus.busy     = busy_q;
    assign bus.rd_done  = rd_done_q;

    // Next-state logic: FSM, issue/in-flight accounting and prefetch buffer pointers.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        issue_left_d = issue_left_q;
        tx_left_d    = tx_left_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
`ifdef RD_CHKSUM_EN
        chk_d        = chk_q;
        if (pop_data_s) begin
            chk_d = chk_q + tx_data_s;
        end else begin
            chk_d = chk_q;
        end
`endif
        if (gnt_s) begin
            addr_d       = addr_q + 32'd4;
            issue_left_d = issue_left_q - 32'd1;
        end else begin
            addr_d       = addr_q;
        end
        in_flight_d = in_flight_q + {{(CW-1){1'b0}}, gnt_s} - {{(CW-1){1'b0}}, rvalid_s};
        cnt_d       = cnt_q + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_data_s};
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_data_s) begin
            rd_ptr_d  = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
            tx_left_d = tx_left_q - 32'd1;
        end else begin
            rd_ptr_d  = rd_ptr_q;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.spi_done && (bus.spi_rx_data[7:0] == CMD_READ)) begin
                    state_d = S_GET_ADDR;
`ifdef RD_CHKSUM_EN
                    chk_d   = {WIDTH{1'b0}};
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GET_ADDR: begin
                if (abort_s) begin
                    state_d = S_FLUSH;
                end else if (bus.spi_done) begin
                    addr_d  = {bus.spi_rx_data[WIDTH-1:2], 2'b00};
                    state_d = S_GET_SIZE;
                end else begin
                    state_d = S_GET_ADDR;
                end
            end
            S_GET_SIZE: begin
                if (abort_s) begin
                    state_d = S_FLUSH;
                end else if (bus.spi_done) begin
                    issue_left_d = bus.spi_rx_data;
                    tx_left_d    = bus.spi_rx_data;
`ifdef RD_CHKSUM_EN
                    state_d      = S_XFER;
`else
                    state_d      = (bus.spi_rx_data == {WIDTH{1'b0}}) ? S_DONE : S_XFER;
`endif
                end else begin
                    state_d = S_GET_SIZE;
                end
            end
            S_XFER: begin
                if (abort_s) begin
                    state_d = S_FLUSH;
`ifdef RD_CHKSUM_EN
                end else if (pop_trl_s) begin
`else
                end else if (pop_data_s && (tx_left_q == 32'd1)) begin
`endif
                    state_d = S_DONE;
                end else begin
                    state_d = S_XFER;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_FLUSH: begin
                if ((in_flight_d == {CW{1'b0}}) && !req_hold_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_FLUSH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort_s) begin
            cnt_d    = {CW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            wr_ptr_d = {PW{1'b0}};
        end else begin
            cnt_d    = cnt_d;
        end

        // A granted request always has a buffer slot reserved, so the buffer cannot overflow.
        occ_s = {1'b0, cnt_d} + {1'b0, in_flight_d};
        if (req_hold_s) begin
            req_d = 1'b1;
        end else if ((state_d == S_XFER) && (issue_left_d != {WIDTH{1'b0}}) && (occ_s < DEPTH_C)) begin
            req_d = 1'b1;
        end else begin
            req_d = 1'b0;
        end
    end

    // State, counters, buffer storage and registered outputs.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            state_q      <= S_IDLE;
            addr_q       <= {WIDTH{1'b0}};
            issue_left_q <= {WIDTH{1'b0}};
            tx_left_q    <= {WIDTH{1'b0}};
            in_flight_q  <= {CW{1'b0}};
            cnt_q        <= {CW{1'b0}};
            wr_ptr_q     <= {PW{1'b0}};
            rd_ptr_q     <= {PW{1'b0}};
            req_q        <= 1'b0;
            busy_q       <= 1'b0;
            rd_done_q    <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_q[i] <= {WIDTH{1'b0}};
            end
`ifdef RD_CHKSUM_EN
            chk_q        <= {WIDTH{1'b0}};
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            issue_left_q <= issue_left_d;
            tx_left_q    <= tx_left_d;
            in_flight_q  <= in_flight_d;
            cnt_q        <= cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            req_q        <= req_d;
            busy_q       <= (state_d != S_IDLE);
            rd_done_q    <= (state_d == S_DONE);
            if (push_s) begin
                buf_q[wr_ptr_q] <= bus.mem_rdata;
            end
`ifdef RD_CHKSUM_EN
            chk_q        <= chk_d;
`endif
        end
    end
endmodule

// File: tb/tb_ram_read_responder.sv
// Randomized self-checking bench for ram_read_responder with a RAM/transmitter environment
// and a transfer-level reference model (expected addresses, words and trailer).
`timescale 1ns/1ps
module tb_ram_read_responder;
    logic clk_sys = 1'b0;
    logic rst_sys_n;
    always #5 clk_sys = ~clk_sys;

    ram_read_responder_if #(.WIDTH(32)) bus ();
    ram_read_responder #(.WIDTH(32), .BUF_DEPTH(4), .CMD_READ(8'h02)) dut (
        .clk_sys(clk_sys), .rst_sys_n(rst_sys_n), .bus(bus));

    int chk_cnt = 0, pass_cnt = 0;
    int ready_pct = 100, gnt_pct = 100, rv_pct = 100;
    logic [31:0] seed;
    logic [31:0] ovr [logic [31:0]];
    logic [31:0] pend_q [$];
    logic [31:0] tx_q [$], gnt_q [$], exp_tx [$], exp_gnt [$];
    int rv_cnt, rd_done_cnt, proto_err, cyc, last_tx_cyc, rd_done_cyc;
    logic p_req, p_gnt, p_valid, p_ready, p_abort, p_done;
    logic [31:0] p_addr, p_data;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (ovr.exists(a)) return ovr[a];
        return (a * 32'h9E37_79B1) ^ seed;
    endfunction

    function automatic int q_diff(input logic [31:0] a [$], input logic [31:0] b [$]);
        if (a.size() != b.size()) return -2;
        for (int i = 0; i < a.size(); i++) if (a[i] !== b[i]) return i;
        return -1;
    endfunction

    // RAM and transmitter environment: random grant/rvalid/ready, in-order read data.
    initial begin
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0; bus.tx_ready = 1'b0;
        forever begin
            @(posedge clk_sys); #1;
            if (!rst_sys_n) begin
                pend_q.delete();
                bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.tx_ready = 1'b0;
            end else begin
                bus.tx_ready = ($urandom_range(0, 99) < ready_pct);
                if (pend_q.size() > 0 && $urandom_range(0, 99) < rv_pct) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = mem_word(pend_q.pop_front());
                end else begin
                    bus.mem_rvalid = 1'b0;
                    bus.mem_rdata  = $urandom();
                end
                bus.mem_gnt = ($urandom_range(0, 99) < gnt_pct);
                if (bus.mem_req && bus.mem_gnt) pend_q.push_back(bus.mem_addr);
            end
        end
    end

    // Monitor: logs handshakes and counts protocol violations on the falling edge.
    initial begin
        cyc = 0;
        forever begin
            @(negedge clk_sys);
            cyc++;
            if (rst_sys_n) begin
                if (p_req && !p_gnt && (!bus.mem_req || bus.mem_addr !== p_addr)) proto_err++;
                if (p_valid && !p_ready && !p_abort && (!bus.tx_valid || bus.tx_data !== p_data)) proto_err++;
                if (p_done && bus.rd_done) proto_err++;
                if (bus.mem_req && bus.mem_gnt) gnt_q.push_back(bus.mem_addr);
                if (bus.tx_valid && bus.tx_ready) begin tx_q.push_back(bus.tx_data); last_tx_cyc = cyc; end
                if (bus.mem_rvalid) rv_cnt++;
                if (bus.rd_done) begin rd_done_cnt++; rd_done_cyc = cyc; end
                p_req = bus.mem_req; p_gnt = bus.mem_gnt; p_addr = bus.mem_addr;
                p_valid = bus.tx_valid; p_ready = bus.tx_ready; p_data = bus.tx_data;
                p_abort = bus.abort; p_done = bus.rd_done;
            end else begin
                p_req = 1'b0; p_valid = 1'b0; p_done = 1'b0; p_gnt = 1'b0; p_ready = 1'b0; p_abort = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk_sys); #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        bus.spi_done = 1'b1; bus.spi_rx_data = w;
        tick();
        bus.spi_done = 1'b0; bus.spi_rx_data = $urandom();
        repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic clear_logs();
        tx_q.delete(); gnt_q.delete();
        rv_cnt = 0; rd_done_cnt = 0; proto_err = 0; last_tx_cyc = -10; rd_done_cyc = -20;
    endtask

    // Reference model: a transfer reads consecutive words from the aligned base, wrapping at 2^32.
    task automatic build_expect(input logic [31:0] a, input logic [31:0] n);
        logic [31:0] base, sum, wa;
        base = {a[31:2], 2'b00};
        sum = 32'h0;
        exp_gnt.delete(); exp_tx.delete();
        for (int i = 0; i < int'(n); i++) begin
            wa = base + 32'(4 * i);
            exp_gnt.push_back(wa);
            exp_tx.push_back(mem_word(wa));
            sum = sum + mem_word(wa);
        end
`ifdef RD_CHKSUM_EN
        exp_tx.push_back(sum);
`endif
    endtask

    task automatic start_xfer(input logic [31:0] a, input logic [31:0] n);
        logic [31:0] cmd;
        clear_logs();
        build_expect(a, n);
        cmd = $urandom();
        cmd[7:0] = 8'h02;
        send_word(cmd);
        send_word(a);
        send_word(n);
    endtask

    task automatic wait_idle(input int limit, output bit to);
        to = 1'b1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk_sys);
            if (bus.busy === 1'b0) begin to = 1'b0; break; end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_sys_n = 1'b0;
        repeat (3) tick();
        @(negedge clk_sys);
        chk_cnt++;
        if ({bus.mem_req, bus.tx_valid, bus.busy, bus.rd_done} !== 4'b0000) begin
            $display("FAIL reset_flags: got %b required 0000", {bus.mem_req, bus.tx_valid, bus.busy, bus.rd_done});
        end else pass_cnt++;
        chk_cnt++;
        if (bus.mem_addr !== 32'h0) $display("FAIL reset_addr: got %h required 0", bus.mem_addr);
        else pass_cnt++;
        tick();
        rst_sys_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        bit to; int d;
        ready_pct = 100; gnt_pct = 100; rv_pct = 100;
        start_xfer(32'h100, 32'd3);
        wait_idle(200, to);
        chk_cnt++; if (to !== 1'b0) $display("FAIL basic_timeout: busy still high"); else pass_cnt++;
        d = q_diff(gnt_q, exp_gnt);
        chk_cnt++; if (d != -1) $display("FAIL basic_addr: got %0d grants (diff %0d) required %0d", gnt_q.size(), d, exp_gnt.size()); else pass_cnt++;
        d = q_diff(tx_q, exp_tx);
        chk_cnt++; if (d != -1) $display("FAIL basic_tx: got %0d words (diff %0d) required %0d", tx_q.size(), d, exp_tx.size()); else pass_cnt++;
        chk_cnt++; if (rd_done_cnt != 1) $display("FAIL basic_rd_done: got %0d pulses required 1", rd_done_cnt); else pass_cnt++;
        chk_cnt++; if (rd_done_cyc != last_tx_cyc + 1) $display("FAIL basic_done_timing: got cycle %0d required %0d", rd_done_cyc, last_tx_cyc + 1); else pass_cnt++;
        chk_cnt++; if (proto_err != 0) $display("FAIL basic_proto: got %0d violations required 0", proto_err); else pass_cnt++;
    endtask

    task automatic test_random();
        bit to; int d;
        logic [31:0] a, n;
        for (int it = 0; it < 6; it++) begin
            ready_pct = $urandom_range(20, 100); gnt_pct = $urandom_range(20, 100); rv_pct = $urandom_range(20, 100);
            a = $urandom(); n = $urandom_range(1, 12);
            start_xfer(a, n);
            wait_idle(3000, to);
            chk_cnt++; if (to !== 1'b0) $display("FAIL rand_timeout: iter %0d", it); else pass_cnt++;
            d = q_diff(gnt_q, exp_gnt);
            chk_cnt++; if (d != -1) $display("FAIL rand_addr: iter %0d got %0d grants (diff %0d) required %0d", it, gnt_q.size(), d, exp_gnt.size()); else pass_cnt++;
            d = q_diff(tx_q, exp_tx);
            chk_cnt++; if (d != -1) $display("FAIL rand_tx: iter %0d got %0d words (diff %0d) required %0d", it, tx_q.size(), d, exp_tx.size()); else pass_cnt++;
            chk_cnt++; if (rd_done_cnt != 1 || rd_done_cyc != last_tx_cyc + 1) $display("FAIL rand_rd_done: iter %0d got %0d pulses at %0d required 1 at %0d", it, rd_done_cnt, rd_done_cyc, last_tx_cyc + 1); else pass_cnt++;
            chk_cnt++; if (proto_err != 0) $display("FAIL rand_proto: iter %0d got %0d violations required 0", it, proto_err); else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        bit to; int d;
        ready_pct = 0; gnt_pct = 100; rv_pct = 100;
        start_xfer($urandom(), 32'd10);
        repeat (20) @(negedge clk_sys);
        #1;
        chk_cnt++; if (gnt_q.size() != 4) $display("FAIL bp_grants: got %0d required 4", gnt_q.size()); else pass_cnt++;
        chk_cnt++; if (bus.mem_req !== 1'b0 || tx_q.size() != 0) $display("FAIL bp_req_low: got req %b words %0d required 0 0", bus.mem_req, tx_q.size()); else pass_cnt++;
        ready_pct = 100;
        wait_idle(500, to);
        d = q_diff(tx_q, exp_tx);
        chk_cnt++; if (to !== 1'b0 || d != -1) $display("FAIL bp_tx: got %0d words (diff %0d) required %0d", tx_q.size(), d, exp_tx.size()); else pass_cnt++;
        d = q_diff(gnt_q, exp_gnt);
        chk_cnt++; if (d != -1) $display("FAIL bp_addr: got %0d grants (diff %0d) required %0d", gnt_q.size(), d, exp_gnt.size()); else pass_cnt++;
    endtask

    task automatic test_ignore_cmd();
        bit to; int d;
        ready_pct = 100; gnt_pct = 100; rv_pct = 100;
        send_word(32'h0000_0001);
        repeat (3) @(negedge clk_sys);
        chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL ign_busy: got %b required 0", bus.busy); else pass_cnt++;
        start_xfer(32'h0, 32'd0);
        wait_idle(100, to);
        chk_cnt++; if (to !== 1'b0 || gnt_q.size() != 0) $display("FAIL size0_req: got %0d grants required 0", gnt_q.size()); else pass_cnt++;
        d = q_diff(tx_q, exp_tx);
        chk_cnt++; if (d != -1) $display("FAIL size0_tx: got %0d words required %0d", tx_q.size(), exp_tx.size()); else pass_cnt++;
        chk_cnt++; if (rd_done_cnt != 1) $display("FAIL size0_rd_done: got %0d required 1", rd_done_cnt); else pass_cnt++;
    endtask

    task automatic test_wrap();
        bit to; int d;
        start_xfer(32'hFFFF_FFFC, 32'd2);
        wait_idle(200, to);
        chk_cnt++; if (to !== 1'b0 || gnt_q.size() != 2 || gnt_q[0] !== 32'hFFFF_FFFC || gnt_q[1] !== 32'h0)
            $display("FAIL wrap_addr: got %0d grants required FFFFFFFC,00000000", gnt_q.size()); else pass_cnt++;
        d = q_diff(tx_q, exp_tx);
        chk_cnt++; if (d != -1) $display("FAIL wrap_tx: got %0d words (diff %0d) required %0d", tx_q.size(), d, exp_tx.size()); else pass_cnt++;
    endtask

    task automatic test_abort();
        bit to, bad; int d;
        ready_pct = 100; gnt_pct = 100; rv_pct = 0;
        start_xfer($urandom(), 32'd8);
        for (int i = 0; i < 50 && gnt_q.size() < 2; i++) begin @(negedge clk_sys); #1; end
        gnt_pct = 0;
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk_sys);
            if (bus.mem_req !== 1'b1 || bus.tx_valid !== 1'b0 || bus.busy !== 1'b1) bad = 1'b1;
        end
        chk_cnt++; if (bad) $display("FAIL abort_hold: req/tx_valid/busy got %b%b%b required 101", bus.mem_req, bus.tx_valid, bus.busy); else pass_cnt++;
        gnt_pct = 100; rv_pct = 100;
        wait_idle(100, to);
        chk_cnt++; if (to !== 1'b0 || gnt_q.size() != 3 || rv_cnt != 3) $display("FAIL abort_flush: got %0d grants %0d rvalids required 3 3", gnt_q.size(), rv_cnt); else pass_cnt++;
        chk_cnt++; if (tx_q.size() != 0 || rd_done_cnt != 0) $display("FAIL abort_quiet: got %0d words %0d rd_done required 0 0", tx_q.size(), rd_done_cnt); else pass_cnt++;
        ready_pct = 70;
        start_xfer($urandom(), 32'd5);
        wait_idle(500, to);
        d = q_diff(tx_q, exp_tx);
        chk_cnt++; if (to !== 1'b0 || d != -1 || rd_done_cnt != 1) $display("FAIL abort_next: got %0d words (diff %0d) required %0d", tx_q.size(), d, exp_tx.size()); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bit to; int d;
        ready_pct = 0; gnt_pct = 100; rv_pct = 100;
        start_xfer($urandom(), 32'd8);
        repeat (10) @(negedge clk_sys);
        #2 rst_sys_n = 1'b0;
        #1;
        chk_cnt++;
        if ({bus.mem_req, bus.tx_valid, bus.busy, bus.rd_done} !== 4'b0000 || bus.mem_addr !== 32'h0)
            $display("FAIL rst_mid: got flags %b addr %h required 0000 0", {bus.mem_req, bus.tx_valid, bus.busy, bus.rd_done}, bus.mem_addr);
        else pass_cnt++;
        repeat (2) tick();
        rst_sys_n = 1'b1;
        ready_pct = 100;
        tick();
        start_xfer($urandom(), 32'd5);
        wait_idle(500, to);
        d = q_diff(tx_q, exp_tx);
        chk_cnt++; if (to !== 1'b0 || d != -1 || rd_done_cnt != 1) $display("FAIL rst_after: got %0d words (diff %0d) required %0d", tx_q.size(), d, exp_tx.size()); else pass_cnt++;
    endtask

`ifdef RD_CHKSUM_EN
    task automatic test_chksum();
        bit to; int d;
        ready_pct = 100; gnt_pct = 100; rv_pct = 100;
        ovr[32'h200] = 32'hFFFF_FFFF;
        ovr[32'h204] = 32'h0000_0002;
        start_xfer(32'h200, 32'd2);
        wait_idle(200, to);
        chk_cnt++; if (to !== 1'b0 || tx_q.size() != 3 || tx_q[2] !== 32'h0000_0001) $display("FAIL chk_trailer: got %0d words required trailer 00000001", tx_q.size()); else pass_cnt++;
        d = q_diff(tx_q, exp_tx);
        chk_cnt++; if (d != -1) $display("FAIL chk_tx: got %0d words (diff %0d) required %0d", tx_q.size(), d, exp_tx.size()); else pass_cnt++;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        seed = $urandom();
        rst_sys_n = 1'b0;
        bus.spi_done = 1'b0; bus.spi_rx_data = 32'h0; bus.abort = 1'b0;
        clear_logs();
        test_reset();
        test_basic();
        test_random();
        test_backpressure();
        test_ignore_cmd();
        test_wrap();
        test_abort();
        test_reset_mid();
`ifdef RD_CHKSUM_EN
        test_chksum();
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
